// File: rtl/mode_step_counter_if.sv
// Control and status bundle between the mode decoder/sequencer and the step counter.
interface mode_step_counter_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] maxNum;
    logic             start;
    logic             clear;
    logic             tick;
    logic             repeat_en;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output maxNum, start, clear, tick, repeat_en,
        input  count, busy, done, wrap
    );

    modport slave (
        input  maxNum, start, clear, tick, repeat_en,
        output count, busy, done, wrap
    );
endinterface

// File: rtl/mode_step_counter.sv
// Steps a counter from 0 to a latched limit on each tick, either finishing once
// with a done pulse or wrapping back to 0 with a wrap pulse; all outputs registered.
module mode_step_counter #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    mode_step_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             rep_q,   rep_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             wrap_q,  wrap_d;

    logic start_ok;
    logic at_limit;

    // A start with maxNum==0 means the mode is off and is dropped.
    assign start_ok = bus.start && (bus.maxNum != '0);
    assign at_limit = (count_q == limit_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start_ok) state_d = RUN;
                RUN:     if (bus.tick && at_limit && !rep_q) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // busy follows the next state so it is registered alongside it.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        rep_d   = rep_q;
        busy_d  = (state_d == RUN);
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        limit_d = bus.maxNum;
                        rep_d   = bus.repeat_en;
                        count_d = '0;
                    end
                end
                RUN: begin
                    if (bus.tick) begin
                        if (!at_limit) begin
                            count_d = count_q + WIDTH'(1);
                        end else if (rep_q) begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_mode_step_counter.sv
// Scoreboard bench: the driver pushes the reference model's expected outputs per
// cycle, and a monitor pops and compares them one step after each rising edge.
module tb_mode_step_counter;
    localparam int WIDTH = 5;

    logic clk;
    logic rst_n;

    mode_step_counter_if #(.WIDTH(WIDTH)) bus ();

    mode_step_counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit done;
        bit wrap;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: run phase, position within the run and latched run settings.
    bit m_running;
    bit m_finishing;
    int m_pos;
    int m_lim;
    bit m_rep;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_running   = 0;
        m_finishing = 0;
        m_pos       = 0;
        m_lim       = 0;
        m_rep       = 0;
    endtask

    // One clock of stimulus: drive at the falling edge, predict the state after the next rise.
    task automatic cycle(input bit st, input bit clr, input bit tk, input bit rep, input int mx);
        exp_t e;
        bit   pulse_done;
        bit   pulse_wrap;
        @(negedge clk);
        bus.start     = st;
        bus.clear     = clr;
        bus.tick      = tk;
        bus.repeat_en = rep;
        bus.maxNum    = WIDTH'(mx);
        pulse_done = 0;
        pulse_wrap = 0;
        if (clr) begin
            m_running   = 0;
            m_finishing = 0;
            m_pos       = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
        end else if (m_running) begin
            if (tk) begin
                if (m_rep) begin
                    m_pos      = (m_pos + 1) % (m_lim + 1);
                    pulse_wrap = (m_pos == 0);
                end else if (m_pos == m_lim) begin
                    m_running   = 0;
                    m_finishing = 1;
                    pulse_done  = 1;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end else if (st && mx > 0) begin
            m_running = 1;
            m_lim     = mx;
            m_rep     = rep;
            m_pos     = 0;
        end
        e.count = m_pos;
        e.busy  = m_running;
        e.done  = pulse_done;
        e.wrap  = pulse_wrap;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, $urandom_range(0, 31));
    endtask

    task automatic ticks(input int n, input int mx);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, $urandom_range(0, 1), mx);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count", int'(bus.count), e.count);
                check("busy",  int'(bus.busy),  int'(e.busy));
                check("done",  int'(bus.done),  int'(e.done));
                check("wrap",  int'(bus.wrap),  int'(e.wrap));
            end
        end
    end

    initial begin : driver
        int mx;
        bus.start = 0; bus.clear = 0; bus.tick = 0; bus.repeat_en = 0; bus.maxNum = '0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_done",  int'(bus.done),  0);
        check("rst_wrap",  int'(bus.wrap),  0);
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot to 6, then a few idle cycles with count parked at 6.
        cycle(1, 0, 0, 0, 6);
        ticks(7, 6);
        idle(3);

        // Repeat to 5: 13 ticks, two wraps, then abort.
        cycle(1, 0, 0, 1, 5);
        ticks(13, 5);
        cycle(0, 1, 0, 0, 5);

        // Zero mode ignored, then one-shot to 11.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
        cycle(1, 0, 0, 0, 11);
        ticks(12, 11);
        cycle(1, 0, 0, 0, 9);
        idle(2);

        // Limit latched at 16 even though maxNum drops to 5 mid-run.
        cycle(1, 0, 0, 0, 16);
        ticks(4, 16);
        ticks(13, 5);
        idle(1);

        // clear beats start and tick, both from IDLE and from RUN.
        cycle(1, 1, 1, 0, 12);
        cycle(1, 0, 0, 0, 12);
        ticks(3, 12);
        cycle(1, 1, 1, 0, 12);
        idle(1);

        // Ticks with gaps and mid-run start pulses.
        cycle(1, 0, 0, $urandom_range(0, 1), 11);
        for (int i = 0; i < 60; i++)
            cycle($urandom_range(0, 3) == 0, 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                  $urandom_range(0, 31));
        cycle(0, 1, 0, 0, 0);

        // Full-range limit in both modes.
        cycle(1, 0, 0, 1, 31);
        ticks(34, 31);
        cycle(0, 1, 0, 0, 31);
        cycle(1, 0, 0, 0, 31);
        ticks(33, 31);
        idle(1);

        // Asynchronous reset mid-run with count at 3.
        cycle(1, 0, 0, 0, 10);
        ticks(3, 10);
        @(posedge clk);
        #3;
        check("pre_rst_count", int'(bus.count), 3);
        rst_n = 1'b0;
        #1;
        check("arst_count", int'(bus.count), 0);
        check("arst_busy",  int'(bus.busy),  0);
        check("arst_done",  int'(bus.done),  0);
        check("arst_wrap",  int'(bus.wrap),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random soak.
        for (int i = 0; i < 400; i++) begin
            mx = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            if ($urandom_range(0, 15) == 0) mx = 31;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 1), mx);
        end
        idle(2);

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time %0t exceeded, required finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
